// File: rtl/bp_cfg_pkg.sv
// Shared config-bus definitions: register map, CCE mode encoding and the
// write-beat layout used by the boot sequencer and its consumers.
package bp_cfg_pkg;

  localparam int cfg_core_width_gp = 8;
  localparam int cfg_addr_width_gp = 16;
  localparam int cfg_data_width_gp = 64;

  localparam logic [15:0] bp_cfg_reg_freeze_gp   = 16'h0001;
  localparam logic [15:0] bp_cfg_reg_npc_gp      = 16'h0002;
  localparam logic [15:0] bp_cfg_reg_cce_mode_gp = 16'h0003;

  typedef enum logic {
    e_cce_mode_uncached = 1'b0,
    e_cce_mode_normal   = 1'b1
  } bp_cce_mode_e;

  typedef struct packed {
    logic [cfg_core_width_gp-1:0] core;
    logic [cfg_addr_width_gp-1:0] addr;
    logic [cfg_data_width_gp-1:0] data;
  } bp_cfg_bus_s;

endpackage

// File: rtl/bsg_counter_clear_up.sv
// Up counter with synchronous reset and clear; clear takes priority over up.
module bsg_counter_clear_up #(
  parameter int width_p    = 1,
  parameter int init_val_p = 0
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               clear_i,
  input  logic               up_i,
  output logic [width_p-1:0] count_o
);

  logic [width_p-1:0] count_r;

  // Counter state: reset/clear return to the initial value, otherwise count up.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      count_r <= width_p'(init_val_p);
    end else if (clear_i) begin
      count_r <= width_p'(init_val_p);
    end else if (up_i) begin
      count_r <= count_r + width_p'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign count_o = count_r;

endmodule

// File: rtl/bp_cfg_sequencer.sv
// Boot-time config-bus master: freezes every core, writes boot PC and CCE
// mode per core, then unfreezes all cores once every core is configured.
module bp_cfg_sequencer
  import bp_cfg_pkg::*;
#(
  parameter int num_core_p       = 2,
  parameter int cfg_core_width_p = 8,
  parameter int cfg_addr_width_p = 16,
  parameter int cfg_data_width_p = 64,
  parameter int vaddr_width_p    = 39
) (
  input  logic                        clk_i,
  input  logic                        reset_n_i,
  input  logic                        start_i,
  input  logic [vaddr_width_p-1:0]    boot_pc_i,
  input  logic                        cce_mode_i,
  output logic                        cfg_v_o,
  input  logic                        cfg_ready_i,
  output logic [cfg_core_width_p-1:0] cfg_core_o,
  output logic [cfg_addr_width_p-1:0] cfg_addr_o,
  output logic [cfg_data_width_p-1:0] cfg_data_o,
  output logic                        busy_o,
  output logic                        done_o
);

  localparam int cnt_width_lp = (num_core_p > 1) ? $clog2(num_core_p) : 1;

  typedef enum logic [2:0] {
    e_idle     = 3'd0,
    e_freeze   = 3'd1,
    e_npc      = 3'd2,
    e_mode     = 3'd3,
    e_unfreeze = 3'd4,
    e_done     = 3'd5
  } state_e;

  state_e                      state_r;
  logic [vaddr_width_p-1:0]    boot_pc_r;
  bp_cce_mode_e                cce_mode_r;
  logic                        cfg_v_r;
  logic                        busy_r;
  logic                        done_r;
  logic [cfg_addr_width_p-1:0] cfg_addr_r;
  logic [cfg_data_width_p-1:0] cfg_data_r;
  logic [cnt_width_lp-1:0]     core_cnt_s;

  logic fire_s;
  logic last_core_s;
  logic start_accept_s;
  logic reset_s;
  logic cnt_clear_s;
  logic cnt_up_s;

  // Handshake, wrap detection and core-counter control.
  always_comb begin
    fire_s         = cfg_v_r & cfg_ready_i;
    last_core_s    = (core_cnt_s == cnt_width_lp'(num_core_p - 1));
    start_accept_s = start_i & ((state_r == e_idle) | (state_r == e_done));
    reset_s        = ~reset_n_i;
    cnt_clear_s    = 1'b0;
    cnt_up_s       = 1'b0;
    // The counter is also cleared after the final unfreeze so cfg_core_o idles at 0.
    if (fire_s & ((state_r == e_mode) | (state_r == e_unfreeze))) begin
      cnt_clear_s = last_core_s;
      cnt_up_s    = ~last_core_s;
    end else begin
      cnt_clear_s = start_accept_s;
    end
  end

  bsg_counter_clear_up #(
    .width_p    (cnt_width_lp),
    .init_val_p (0)
  ) core_counter (
    .clk_i   (clk_i),
    .reset_i (reset_s),
    .clear_i (cnt_clear_s),
    .up_i    (cnt_up_s),
    .count_o (core_cnt_s)
  );

  // Program FSM; the next write's address/data are registered on each transition.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_r    <= e_idle;
      boot_pc_r  <= '0;
      cce_mode_r <= e_cce_mode_uncached;
      cfg_v_r    <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      cfg_addr_r <= '0;
      cfg_data_r <= '0;
    end else begin
      case (state_r)
        e_idle, e_done: begin
          if (start_i) begin
            state_r    <= e_freeze;
            boot_pc_r  <= boot_pc_i;
            cce_mode_r <= bp_cce_mode_e'(cce_mode_i);
            cfg_v_r    <= 1'b1;
            busy_r     <= 1'b1;
            done_r     <= 1'b0;
            cfg_addr_r <= cfg_addr_width_p'(bp_cfg_reg_freeze_gp);
            cfg_data_r <= cfg_data_width_p'(1'b1);
          end
        end
        e_freeze: begin
          if (fire_s) begin
            state_r    <= e_npc;
            cfg_addr_r <= cfg_addr_width_p'(bp_cfg_reg_npc_gp);
            cfg_data_r <= cfg_data_width_p'(boot_pc_r);
          end
        end
        e_npc: begin
          if (fire_s) begin
            state_r    <= e_mode;
            cfg_addr_r <= cfg_addr_width_p'(bp_cfg_reg_cce_mode_gp);
            cfg_data_r <= cfg_data_width_p'(cce_mode_r);
          end
        end
        e_mode: begin
          if (fire_s) begin
            state_r    <= last_core_s ? e_unfreeze : e_freeze;
            cfg_addr_r <= cfg_addr_width_p'(bp_cfg_reg_freeze_gp);
            cfg_data_r <= last_core_s ? '0 : cfg_data_width_p'(1'b1);
          end
        end
        e_unfreeze: begin
          if (fire_s & last_core_s) begin
            state_r    <= e_done;
            cfg_v_r    <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b1;
            cfg_addr_r <= '0;
            cfg_data_r <= '0;
          end
        end
        default: begin
          state_r    <= e_idle;
          cfg_v_r    <= 1'b0;
          busy_r     <= 1'b0;
          done_r     <= 1'b0;
          cfg_addr_r <= '0;
          cfg_data_r <= '0;
        end
      endcase
    end
  end

  assign cfg_v_o    = cfg_v_r;
  assign cfg_core_o = cfg_core_width_p'(core_cnt_s);
  assign cfg_addr_o = cfg_addr_r;
  assign cfg_data_o = cfg_data_r;
  assign busy_o     = busy_r;
  assign done_o     = done_r;

endmodule

// File: tb/tb_bp_cfg_sequencer.sv
// Scoreboard bench for bp_cfg_sequencer: a 2-core and a 1-core instance,
// expected writes queued at stimulus time and popped by per-DUT monitors.
module tb_bp_cfg_sequencer;
  import bp_cfg_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic        start_a, ready_a, mode_a, v_a, busy_a, done_a;
  logic [38:0] pc_a;
  logic [7:0]  core_a;
  logic [15:0] addr_a;
  logic [63:0] data_a;
  logic        start_b, ready_b, mode_b, v_b, busy_b, done_b;
  logic [38:0] pc_b;
  logic [7:0]  core_b;
  logic [15:0] addr_b;
  logic [63:0] data_b;

  bp_cfg_sequencer #(.num_core_p(2)) dut_a (
    .clk_i(clk), .reset_n_i(reset_n), .start_i(start_a), .boot_pc_i(pc_a),
    .cce_mode_i(mode_a), .cfg_v_o(v_a), .cfg_ready_i(ready_a), .cfg_core_o(core_a),
    .cfg_addr_o(addr_a), .cfg_data_o(data_a), .busy_o(busy_a), .done_o(done_a)
  );

  bp_cfg_sequencer #(.num_core_p(1)) dut_b (
    .clk_i(clk), .reset_n_i(reset_n), .start_i(start_b), .boot_pc_i(pc_b),
    .cce_mode_i(mode_b), .cfg_v_o(v_b), .cfg_ready_i(ready_b), .cfg_core_o(core_b),
    .cfg_addr_o(addr_b), .cfg_data_o(data_b), .busy_o(busy_b), .done_o(done_b)
  );

  int checks   = 0;
  int failures = 0;
  bp_cfg_bus_s q_a[$];
  bp_cfg_bus_s q_b[$];
  bp_cfg_bus_s held_a;
  bit          stall_a    = 1'b0;
  int          mode_seen_a = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bp_cfg_bus_s mk(input logic [7:0] c, input logic [15:0] a, input logic [63:0] d);
    bp_cfg_bus_s b;
    b.core = c;
    b.addr = a;
    b.data = d;
    return b;
  endfunction

  // Expected program: per core freeze(1), npc(pc), mode; then unfreeze(0) per core.
  task automatic push_prog(input bit to_b, input int ncore, input logic [38:0] pc, input logic mode);
    bp_cfg_bus_s e[$];
    for (int c = 0; c < ncore; c++) begin
      e.push_back(mk(8'(c), 16'h0001, 64'h1));
      e.push_back(mk(8'(c), 16'h0002, {25'h0, pc}));
      e.push_back(mk(8'(c), 16'h0003, {63'h0, mode}));
    end
    for (int c = 0; c < ncore; c++) e.push_back(mk(8'(c), 16'h0001, 64'h0));
    foreach (e[i]) begin
      if (to_b) q_b.push_back(e[i]);
      else      q_a.push_back(e[i]);
    end
  endtask

  // Monitor A: stall stability, scoreboard pop on accepted writes, unfreeze ordering.
  always @(negedge clk) begin
    bp_cfg_bus_s cur, exp;
    cur = mk(core_a, addr_a, data_a);
    if (!reset_n) begin
      stall_a     = 1'b0;
      mode_seen_a = 0;
    end else begin
      if (stall_a) begin
        chk("a_valid_held", {63'h0, v_a}, 64'h1);
        chk("a_bus_stable", {63'h0, cur == held_a}, 64'h1);
      end
      if (v_a && ready_a) begin
        stall_a = 1'b0;
        chk("a_sb_nonempty", {63'h0, q_a.size() != 0}, 64'h1);
        if (q_a.size() != 0) begin
          exp = q_a.pop_front();
          chk("a_wr_core", {56'h0, core_a}, {56'h0, exp.core});
          chk("a_wr_addr", {48'h0, addr_a}, {48'h0, exp.addr});
          chk("a_wr_data", data_a, exp.data);
        end
        if (addr_a == 16'h0001 && data_a == 64'h1 && core_a == 8'h0) mode_seen_a = 0;
        if (addr_a == 16'h0003) mode_seen_a++;
        if (addr_a == 16'h0001 && data_a == 64'h0)
          chk("a_unfreeze_after_all_modes", 64'(mode_seen_a), 64'd2);
      end else if (v_a) begin
        stall_a = 1'b1;
        held_a  = cur;
      end else begin
        stall_a = 1'b0;
      end
    end
  end

  // Monitor B: scoreboard pop on accepted writes of the single-core instance.
  always @(negedge clk) begin
    bp_cfg_bus_s exp;
    if (reset_n && v_b && ready_b) begin
      chk("b_sb_nonempty", {63'h0, q_b.size() != 0}, 64'h1);
      if (q_b.size() != 0) begin
        exp = q_b.pop_front();
        chk("b_wr_core", {56'h0, core_b}, {56'h0, exp.core});
        chk("b_wr_addr", {48'h0, addr_b}, {48'h0, exp.addr});
        chk("b_wr_data", data_b, exp.data);
      end
    end
  end

  task automatic kick(input bit to_b, input logic [38:0] pc, input logic mode, input bit hold);
    if (to_b) begin
      pc_b = pc; mode_b = mode; start_b = 1'b1;
    end else begin
      pc_a = pc; mode_a = mode; start_a = 1'b1;
    end
    @(posedge clk); #1;
    if (!hold) begin
      start_a = 1'b0;
      start_b = 1'b0;
    end
  endtask

  // Waits (bounded) for done, counting busy cycles; optional ready stall pattern on A.
  task automatic wait_done(input bit use_b, input bit stall, input int bound, output int busy_cycles);
    bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    bit seen = 1'b0;
    busy_cycles = 0;
    for (int i = 0; i < bound; i++) begin
      if (stall) ready_a = (i < 4) ? pat[i] : 1'($urandom_range(0, 1));
      else       ready_a = 1'b1;
      @(negedge clk);
      if (use_b ? done_b : done_a) begin
        seen = 1'b1;
        chk("busy_low_at_done", {63'h0, use_b ? busy_b : busy_a}, 64'h0);
        break;
      end
      if (use_b ? busy_b : busy_a) busy_cycles++;
      @(posedge clk); #1;
    end
    chk("done_within_bound", {63'h0, seen}, 64'h1);
  endtask

  int bc;

  initial begin
    reset_n = 1'b0;
    start_a = 1'b0; ready_a = 1'b0; mode_a = 1'b0; pc_a = 39'h0;
    start_b = 1'b0; ready_b = 1'b1; mode_b = 1'b0; pc_b = 39'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_v",    {63'h0, v_a},    64'h0);
    chk("rst_busy", {63'h0, busy_a}, 64'h0);
    chk("rst_done", {63'h0, done_a}, 64'h0);
    chk("rst_bus",  {63'h0, (core_a == 8'h0) && (addr_a == 16'h0) && (data_a == 64'h0)}, 64'h1);
    chk("rst_b_idle", {63'h0, v_b | busy_b | done_b}, 64'h0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Back-to-back program with ready tied high.
    push_prog(1'b0, 2, 39'h0080000000, 1'b1);
    kick(1'b0, 39'h0080000000, 1'b1, 1'b0);
    wait_done(1'b0, 1'b0, 40, bc);
    chk("t1_busy_cycles", 64'(bc), 64'd8);
    chk("t1_sb_drained", 64'(q_a.size()), 64'd0);

    // Ready stalls 1-0-0-1 then random.
    @(posedge clk); #1;
    push_prog(1'b0, 2, 39'h7FFFFFFFF0, 1'b0);
    kick(1'b0, 39'h7FFFFFFFF0, 1'b0, 1'b0);
    wait_done(1'b0, 1'b1, 300, bc);
    chk("t2_sb_drained", 64'(q_a.size()), 64'd0);

    // Reset while the 4th write is stalled.
    @(posedge clk); #1;
    push_prog(1'b0, 2, 39'h0000ABCDE0, 1'b1);
    while (q_a.size() > 3) void'(q_a.pop_back());
    ready_a = 1'b1;
    kick(1'b0, 39'h0000ABCDE0, 1'b1, 1'b0);
    repeat (3) @(posedge clk);
    #1 ready_a = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("t3_v_after_reset",    {63'h0, v_a},    64'h0);
    chk("t3_busy_after_reset", {63'h0, busy_a}, 64'h0);
    chk("t3_done_after_reset", {63'h0, done_a}, 64'h0);
    chk("t3_sb_three_writes",  64'(q_a.size()), 64'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    ready_a = 1'b1;
    @(posedge clk); #1;
    push_prog(1'b0, 2, 39'h0000ABCDE0, 1'b1);
    kick(1'b0, 39'h0000ABCDE0, 1'b1, 1'b0);
    wait_done(1'b0, 1'b0, 40, bc);
    chk("t3_replay_busy_cycles", 64'(bc), 64'd8);

    // start held high, PC changed right after acceptance.
    @(posedge clk); #1;
    push_prog(1'b0, 2, 39'h0012345678, 1'b1);
    kick(1'b0, 39'h0012345678, 1'b1, 1'b1);
    pc_a = 39'h0055AA55AA;
    wait_done(1'b0, 1'b0, 40, bc);
    chk("t4_no_restart_busy", 64'(bc), 64'd8);
    push_prog(1'b0, 2, 39'h0055AA55AA, 1'b1);
    @(posedge clk); #1;
    start_a = 1'b0;
    @(negedge clk);
    chk("t4_restart_done_clr", {63'h0, done_a}, 64'h0);
    chk("t4_restart_busy",     {63'h0, busy_a}, 64'h1);
    @(posedge clk); #1;
    // One busy cycle of the restarted program was consumed by the check above.
    wait_done(1'b0, 1'b0, 40, bc);
    chk("t4_restart_busy_rest", 64'(bc), 64'd7);
    chk("t4_sb_drained", 64'(q_a.size()), 64'd0);

    // Single-core instance, uncached mode.
    @(posedge clk); #1;
    push_prog(1'b1, 1, 39'h0000001000, 1'b0);
    kick(1'b1, 39'h0000001000, 1'b0, 1'b0);
    wait_done(1'b1, 1'b0, 40, bc);
    chk("t5_busy_cycles", 64'(bc), 64'd4);
    chk("t5_sb_drained", 64'(q_b.size()), 64'd0);

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
